// File: rtl/position_table_dbuf.sv
// position_table_dbuf: double-buffered sprite position table, committed on frame edges and streamed to the renderer.
// Optional commit interrupt enabled by defining POSTAB_IRQ_EN.
module position_table_dbuf #(
  parameter int NUM_SPRITES = 8,
  parameter int COORD_W = 12,
  parameter int ADDR_W = 4,
  parameter int IDX_W = 3
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [ADDR_W-1:0]  avs_address,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  input  logic               avs_read,
  output logic [31:0]        avs_readdata,
  input  logic               refresh_image,
  output logic               pos_valid,
  input  logic               pos_ready,
  output logic [IDX_W-1:0]   pos_index,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               pos_enable,
  output logic               frame_done,
  output logic               irq
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state_q;
  logic [COORD_W-1:0] sh_x_q [NUM_SPRITES];
  logic [COORD_W-1:0] sh_y_q [NUM_SPRITES];
  logic [COORD_W-1:0] ac_x_q [NUM_SPRITES];
  logic [COORD_W-1:0] ac_y_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] sh_en_q, ac_en_q;
  logic refresh_q, commit_pending_q, overrun_q, pos_valid_q, frame_done_q, pos_enable_q;
  logic [7:0] commit_count_q;
  logic [IDX_W-1:0] pos_index_q, nxt_idx, wa;
  logic [COORD_W-1:0] pos_x_q, pos_y_q;
  logic [31:0] readdata_q, rd_d;
  logic entry_wr, ctrl_wr, rise, do_commit, last, irq_flag, unused_wd;
  assign entry_wr = avs_write && (avs_address < ADDR_W'(NUM_SPRITES));
  assign ctrl_wr = avs_write && (avs_address == ADDR_W'(NUM_SPRITES));
  assign rise = refresh_image && !refresh_q;
  assign do_commit = rise && (state_q == IDLE) && commit_pending_q;
  assign last = pos_index_q == IDX_W'(NUM_SPRITES - 1);
  assign nxt_idx = pos_index_q + IDX_W'(1);
  assign wa = avs_address[IDX_W-1:0];
  assign unused_wd = ^avs_writedata;
  always_comb begin
    rd_d = '0;
    if (avs_address < ADDR_W'(NUM_SPRITES)) begin
      rd_d[COORD_W-1:0] = sh_x_q[wa];
      rd_d[16 +: COORD_W] = sh_y_q[wa];
      rd_d[31] = sh_en_q[wa];
    end else if (avs_address == ADDR_W'(NUM_SPRITES)) begin
      rd_d[0] = commit_pending_q;
      rd_d[1] = irq_flag;
      rd_d[2] = state_q == SCAN;
      rd_d[3] = overrun_q;
      rd_d[15:8] = commit_count_q;
    end
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sh_x_q[i] <= '0;
        sh_y_q[i] <= '0;
        ac_x_q[i] <= '0;
        ac_y_q[i] <= '0;
      end
      sh_en_q <= '0;
      ac_en_q <= '0;
      refresh_q <= 1'b0;
      commit_pending_q <= 1'b0;
      overrun_q <= 1'b0;
      commit_count_q <= '0;
      readdata_q <= '0;
      pos_valid_q <= 1'b0;
      pos_index_q <= '0;
      pos_x_q <= '0;
      pos_y_q <= '0;
      pos_enable_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      refresh_q <= refresh_image;
      frame_done_q <= 1'b0;
      if (avs_read) readdata_q <= rd_d;
      if (entry_wr) begin
        sh_x_q[wa] <= avs_writedata[COORD_W-1:0];
        sh_y_q[wa] <= avs_writedata[16 +: COORD_W];
        sh_en_q[wa] <= avs_writedata[31];
      end
      // Commit samples the pre-write shadow and pending bit; a same-cycle CTRL write re-arms pending.
      if (do_commit) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          ac_x_q[i] <= sh_x_q[i];
          ac_y_q[i] <= sh_y_q[i];
        end
        ac_en_q <= sh_en_q;
        commit_count_q <= commit_count_q + 8'd1;
      end
      commit_pending_q <= (ctrl_wr && avs_writedata[0]) ? 1'b1 : do_commit ? 1'b0 : commit_pending_q;
      overrun_q <= (rise && state_q == SCAN) ? 1'b1 : (ctrl_wr && avs_writedata[3]) ? 1'b0 : overrun_q;
      case (state_q)
        IDLE: if (rise) begin
          state_q <= SCAN;
          pos_index_q <= '0;
        end
        SCAN: if (!pos_valid_q) begin
          pos_valid_q <= 1'b1;
          pos_x_q <= ac_x_q[pos_index_q];
          pos_y_q <= ac_y_q[pos_index_q];
          pos_enable_q <= ac_en_q[pos_index_q];
        end else if (pos_ready) begin
          if (last) begin
            pos_valid_q <= 1'b0;
            frame_done_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            pos_index_q <= nxt_idx;
            pos_x_q <= ac_x_q[nxt_idx];
            pos_y_q <= ac_y_q[nxt_idx];
            pos_enable_q <= ac_en_q[nxt_idx];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef POSTAB_IRQ_EN
  logic irq_flag_q;
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) irq_flag_q <= 1'b0;
    else irq_flag_q <= do_commit ? 1'b1 : (ctrl_wr && avs_writedata[1]) ? 1'b0 : irq_flag_q;
  end
  assign irq_flag = irq_flag_q;
`else
  assign irq_flag = 1'b0;
`endif
  assign irq = irq_flag;
  assign avs_readdata = readdata_q;
  assign pos_valid = pos_valid_q;
  assign pos_index = pos_index_q;
  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;
  assign pos_enable = pos_enable_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_position_table_dbuf.sv
// tb_position_table_dbuf: directed self-checking bench for position_table_dbuf (default parameters).
module tb_position_table_dbuf;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] addr = '0;
  logic wr = 1'b0, rd = 1'b0, refresh = 1'b0, ready = 1'b0;
  logic [31:0] wdata = '0, rdata;
  logic valid, en, fd, irq;
  logic [2:0] idx;
  logic [11:0] x, y;
  logic [31:0] r;
  logic [11:0] fx [8];
  logic [11:0] fy [8];
  logic fe [8];
  int nx, nfd, n_chk = 0, n_fail = 0;
`ifdef POSTAB_IRQ_EN
  localparam logic [31:0] IRQB = 32'h2;
`else
  localparam logic [31:0] IRQB = 32'h0;
`endif
  position_table_dbuf dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(addr), .avs_write(wr),
    .avs_writedata(wdata), .avs_read(rd), .avs_readdata(rdata), .refresh_image(refresh),
    .pos_valid(valid), .pos_ready(ready), .pos_index(idx), .pos_x(x), .pos_y(y),
    .pos_enable(en), .frame_done(fd), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic avs_wr(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask
  task automatic avs_rd(input logic [3:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    d = rdata;
  endtask
  task automatic pulse();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
  endtask
  // Drains one scan; mode 0 = always ready, mode 1 = ready pattern 1,0,0 repeating.
  task automatic run_frame(input int mode);
    logic stall, lst;
    logic [31:0] held;
    int fin;
    nx = 0; nfd = 0; stall = 1'b0; lst = 1'b0; fin = -1; held = '0;
    for (int c = 0; c < 80; c++) begin
      ready = (mode == 0) || (c % 3 == 0);
      if (fd) begin
        nfd++;
        check("fd_after_last", {31'b0, lst}, 32'd1);
        fin = c;
      end
      lst = 1'b0;
      if (valid) begin
        if (stall) check("stall_stable", {4'b0, idx, en, y, x}, held);
        held = {4'b0, idx, en, y, x};
        stall = !ready;
        if (ready) begin
          check("order", 32'(idx), 32'(nx));
          fx[idx] = x; fy[idx] = y; fe[idx] = en;
          lst = idx == 3'd7;
          nx++;
        end
      end else stall = 1'b0;
      tick();
      if (fin >= 0 && c >= fin + 2) break;
    end
    ready = 1'b0;
    check("n_xfer", 32'(nx), 32'd8);
    check("n_frame_done", 32'(nfd), 32'd1);
  endtask
  initial begin
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_rdata", rdata, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_fd", {31'b0, fd}, 32'h0);
    avs_rd(4'd8, r); check("rst_ctrl", r, 32'h0);
    avs_wr(4'd3, 32'h8064_00C8);
    avs_wr(4'd5, 32'hFFFF_FFFF);
    avs_rd(4'd3, r); check("rd_e3", r, 32'h8064_00C8);
    avs_rd(4'd5, r); check("rd_e5_mask", r, 32'h8FFF_0FFF);
    pulse();
    check("valid_t1", {31'b0, valid}, 32'h0);
    tick();
    check("valid_t2", {31'b0, valid}, 32'h1);
    check("idx_t2", 32'(idx), 32'h0);
    run_frame(0);
    check("nocommit_x3", 32'(fx[3]), 32'h0);
    check("nocommit_e3", 32'(fe[3]), 32'h0);
    avs_rd(4'd8, r); check("ctrl_nocommit", r, 32'h0);
    avs_wr(4'd8, 32'h1);
    avs_rd(4'd8, r); check("ctrl_pending", r, 32'h1);
    pulse();
    avs_rd(4'd8, r); check("ctrl_commit1", r, 32'h104 | IRQB);
    run_frame(1);
    check("c1_x3", 32'(fx[3]), 32'd200);
    check("c1_y3", 32'(fy[3]), 32'd100);
    check("c1_e3", 32'(fe[3]), 32'h1);
    check("c1_x5", 32'(fx[5]), 32'hFFF);
    check("c1_y5", 32'(fy[5]), 32'hFFF);
    check("c1_x0", 32'(fx[0]), 32'h0);
    check("irq_set", {31'b0, irq}, IRQB >> 1);
    avs_wr(4'd8, 32'h2);
    check("irq_clr", {31'b0, irq}, 32'h0);
    avs_rd(4'd8, r); check("ctrl_irqclr", r, 32'h100);
    avs_wr(4'd0, 32'h0005_0007);
    pulse();
    avs_wr(4'd8, 32'h1);
    pulse();
    avs_rd(4'd8, r); check("ctrl_overrun", r, 32'h10D);
    run_frame(0);
    check("ovr_x0_old", 32'(fx[0]), 32'h0);
    check("ovr_x3_old", 32'(fx[3]), 32'd200);
    avs_rd(4'd8, r); check("ctrl_ovr_idle", r, 32'h109);
    pulse();
    avs_rd(4'd8, r); check("ctrl_commit2", r, 32'h20C | IRQB);
    run_frame(0);
    check("c2_x0", 32'(fx[0]), 32'd7);
    check("c2_y0", 32'(fy[0]), 32'd5);
    check("c2_e0", 32'(fe[0]), 32'h0);
    avs_wr(4'd8, 32'hA);
    avs_rd(4'd8, r); check("ctrl_clr_all", r, 32'h200);
    addr = 4'd8; wdata = 32'h1; wr = 1'b1; refresh = 1'b1;
    tick();
    wr = 1'b0; refresh = 1'b0;
    run_frame(0);
    avs_rd(4'd8, r); check("ctrl_simul_commit", r, 32'h201);
    addr = 4'd1; wdata = 32'h0003_0004; wr = 1'b1; refresh = 1'b1;
    tick();
    wr = 1'b0; refresh = 1'b0;
    run_frame(0);
    check("simwr_x1", 32'(fx[1]), 32'h0);
    check("simwr_y1", 32'(fy[1]), 32'h0);
    avs_rd(4'd1, r); check("simwr_shadow1", r, 32'h0003_0004);
    avs_rd(4'd8, r); check("ctrl_commit3", r, 32'h300 | IRQB);
    avs_wr(4'd8, 32'h1);
    pulse();
    run_frame(0);
    check("c4_x1", 32'(fx[1]), 32'd4);
    check("c4_y1", 32'(fy[1]), 32'd3);
    avs_wr(4'd12, 32'hFFFF_FFFF);
    avs_rd(4'd12, r); check("rd_hi12", r, 32'h0);
    avs_rd(4'd9, r); check("rd_hi9", r, 32'h0);
    avs_rd(4'd8, r); check("ctrl_after_hi", r, 32'h400 | IRQB);
    for (int k = 0; k < 252; k++) begin
      logic seen;
      seen = 1'b0;
      avs_wr(4'd8, 32'h1);
      pulse();
      ready = 1'b1;
      for (int c = 0; c < 30 && !seen; c++) begin
        seen = fd;
        tick();
      end
      ready = 1'b0;
      check("wrap_frame_done", {31'b0, seen}, 32'h1);
    end
    avs_rd(4'd8, r); check("ctrl_wrap", r, 32'h000 | IRQB);
    pulse();
    tick(); tick();
    check("mid_valid", {31'b0, valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", {31'b0, valid}, 32'h0);
    check("rstmid_irq", {31'b0, irq}, 32'h0);
    check("rstmid_rdata", rdata, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    avs_rd(4'd8, r); check("rstmid_ctrl", r, 32'h0);
    avs_rd(4'd3, r); check("rstmid_sh3", r, 32'h0);
    pulse();
    run_frame(0);
    check("rstmid_x3", 32'(fx[3]), 32'h0);
    check("rstmid_e3", 32'(fe[3]), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/position_table_dbuf.md
Name: position_table_dbuf

Overview:
- Double-buffered, parametrised sprite position table for the HDMI/Nios system; successor to the single 32-bit position PIO.
- CPU writes per-sprite X/Y/enable entries into a shadow bank over an Avalon-MM slave and requests a commit.
- The commit copies shadow to active on the next refresh_image rising edge (frame boundary) so the renderer never sees a torn frame.
- After each frame edge, the active table is streamed to the renderer over a valid/ready interface.

Parameters:
- NUM_SPRITES, 8, number of table entries (2..64).
- COORD_W, 12, width of each X and Y coordinate (1..15).
- ADDR_W, 4, Avalon word-address width; 2**ADDR_W > NUM_SPRITES required.
- IDX_W, 3, pos_index width; 2**IDX_W >= NUM_SPRITES required.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- avs_address  in  ADDR_W  word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, fixed latency 1.
- refresh_image  in  1  frame-boundary level, synchronous to clk_clk.
- pos_valid  out  1  stream valid.
- pos_ready  in  1  stream ready.
- pos_index  out  IDX_W  entry index.
- pos_x  out  COORD_W  X coordinate.
- pos_y  out  COORD_W  Y coordinate.
- pos_enable  out  1  sprite enable.
- frame_done  out  1  one-cycle pulse after the last entry transfers.
- irq  out  1  commit interrupt (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk_clk. Reset is asynchronous and active-low on reset_reset_n.
- Reset values: every output is 0 on reset, including readdata, pos_*, frame_done and irq. Shadow and active banks, commit_pending, commit_count, irq_flag and overrun are 0. FSM enters IDLE.
- Reset asserted mid-scan aborts the scan immediately.
- Register map, entries at addresses 0..NUM_SPRITES-1:
  - [COORD_W-1:0] = X
  - [16+COORD_W-1:16] = Y
  - [31] = enable
  - Other bits are not stored and read as 0.
- CTRL/STATUS register at address NUM_SPRITES:
  - Write bit0=1: set commit_pending.
  - Write bit1=1: clear irq_flag.
  - Write bit3=1: clear overrun.
  - Read: [0] commit_pending, [1] irq_flag, [2] scan_busy, [3] overrun, [15:8] commit_count. Other bits read 0.
- Addresses above NUM_SPRITES: reads return 0, writes are ignored.
- Read timing: avs_readdata is registered and valid the cycle after avs_read. It holds its value until the next read.
- Edge detect: refresh_image is registered; an edge is refresh_image=1 and previous=0.
- Edge in cycle t while FSM is IDLE:
  - At t+1, if commit_pending: active <= shadow (all entries in parallel), commit_pending <= 0, commit_count <= commit_count+1 (8-bit, 255 wraps to 0), irq_flag <= 1.
  - At t+1 the FSM moves IDLE -> SCAN with idx=0.
  - pos_valid is first high at t+2 with entry 0 taken from the updated active bank.
- SCAN: pos_index/x/y/enable present active[idx].
  - Payload stays stable while pos_valid=1 and pos_ready=0.
  - A transfer occurs when valid&ready; the next index is presented the following cycle, giving 1 entry/cycle throughput.
  - All entries are emitted, including disabled ones.
- End of scan: when idx=NUM_SPRITES-1 transfers, pos_valid drops next cycle, frame_done pulses for exactly that cycle, and the FSM returns to IDLE.
- Edge during SCAN: set overrun (sticky); no commit; commit_pending retained; scan continues unchanged and is not restarted.
- Simultaneous CPU commit write and edge: the commit decision uses commit_pending before the write. The write then leaves commit_pending=1 for the next frame.
- Simultaneous shadow write and commit: active receives the pre-write shadow value; the write lands in shadow only.
- Simultaneous irq clear and irq set: set wins.

Optional Feature:
- Macro POSTAB_IRQ_EN.
- Defined: irq = irq_flag (level). Flag is set on each commit and cleared by CTRL write bit1=1.
- Undefined: irq tied 0; irq_flag logic removed; STATUS bit1 reads 0; CTRL write bit1 ignored.

Test Plan:
- Reset, then read CTRL -> readdata 0x00000000 one cycle after avs_read; pos_valid=0, irq=0.
- Write entry 3 = 0x8064_00C8, then read addr 3 -> 0x806400C8 (COORD_W=12). Active is unchanged: after an edge without commit, stream entry 3 shows x=0, y=0, enable=0.
- Write entry 3, write CTRL=1, pulse refresh_image -> at t+1 commit_count=1 and pending=0; stream entry 3 shows x=200, y=100, enable=1; irq=1 with macro defined, 0 without.
- Stream with pos_ready toggling 1,0,0,1... -> 8 transfers in index order 0..7, payload stable during stalls, frame_done single pulse after index 7.
- Second refresh edge mid-scan with commit_pending=1 -> STATUS reads overrun=1 and pending=1, current scan completes unchanged; next edge in IDLE commits.
- 256 commits -> commit_count wraps to 0; reset asserted mid-scan -> pos_valid=0 at once and all state cleared.
